change_payout: RTL
==================

Name: change_payout

Overview:
- Payout end of the coin interface: takes a change amount from the vending FSM and drives a coin hopper, one coin per handshake.
- Uses the same coin encoding as the acceptor side: 01=₹1, 10=₹2, 11=₹3.
- Keeps a per-denomination inventory and selects coins greedily.
- Reports completion, shortfall and hopper jams back to the vending controller.

Parameters:
- HOPPER_DEPTH, 15, coins of each denomination loaded at reset/refill (1..15).
- ACK_TIMEOUT, 8, cycles ISSUE waits for coin_ack before declaring a jam (2..15).
- LOW_MARK, 2, low-stock threshold (used only with LOW_STOCK_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- change_valid  in  1  one-cycle request strobe; sampled only in IDLE.
- change_amt  in  4  amount to pay in ₹ (0..15).
- busy  out  1  high in every state except IDLE.
- coin_out  out  2  denomination being issued; 00 when coin_valid=0.
- coin_valid  out  1  hopper request; held until ack or timeout.
- coin_ack  in  1  hopper dropped the coin; ignored when coin_valid=0.
- refill  in  1  reload all three inventories to HOPPER_DEPTH; honoured in IDLE and JAM only.
- done  out  1  one-cycle completion pulse.
- short  out  1  valid with done: amount not fully paid.
- owed  out  4  unpaid remainder; updated on DONE/JAM entry, held until next request.
- jam  out  1  high while in JAM.
- low_stock  out  1  see Optional Feature.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; remaining=0.
  - inv1, inv2, inv3 = HOPPER_DEPTH.
  - All outputs 0. Outputs drop immediately, including coin_valid mid-ISSUE; that coin is lost, not accounted.
- Internal width rules:
  - remaining is 4 bit; inv counters are 4 bit.
  - Subtraction never underflows: a coin is selected only if d<=remaining and inv_d>0.
- States: IDLE, SELECT, ISSUE, DONE, JAM. All outputs are registered/decoded from state; no combinational path from inputs to outputs.
- IDLE:
  - change_valid=1 -> remaining<=change_amt, owed<=0, go SELECT.
  - change_valid together with refill -> both take effect.
- SELECT (1 cycle):
  - d = largest of {3,2,1} with d<=remaining and inv_d>0.
  - remaining==0 -> DONE.
  - Some d exists -> latch d, go ISSUE.
  - No d exists -> DONE (shortfall).
  - Greedy selection is required even where a non-greedy combination would succeed. Example: amt 4, inv1=0, inv2=2, inv3=1 pays 3, then short with owed 1.
- ISSUE:
  - coin_valid=1 and coin_out=encoding of d, both stable until exit.
  - Timeout counter cleared on entry; increments each cycle without ack.
  - coin_ack=1 -> remaining-=d, inv_d-=1, go SELECT.
  - Counter reaching ACK_TIMEOUT-1 with no ack -> JAM. If ack arrives on that same cycle, the ack wins.
- DONE (1 cycle): done=1; short=(remaining!=0); owed<=remaining; go IDLE.
- JAM:
  - jam=1, busy=1, owed<=remaining on entry.
  - No done pulse.
  - Exit only by refill (reload inventories, jam=0, go IDLE) or reset.
- Requests are not queued: change_valid outside IDLE is dropped.
- Latency:
  - Request edge -> SELECT next cycle -> coin_valid the cycle after (2 cycles).
  - Ack -> next coin_valid 2 cycles later.
  - amt 0 -> done 2 cycles after request.

Optional Feature:
- Macro: LOW_STOCK_EN.
- Defined: low_stock is registered, =1 when any inv <= LOW_MARK; updates the cycle after inventory changes; reset value 0 (inventories full).
- Undefined: low_stock port still present, tied 0; no comparator logic.

Test Plan:
- Reset; amt 7 -> coin_out 11 (ack), 11 (ack), 01 (ack); done with short=0, owed=0; inv3=13, inv1=14; first coin_valid 2 cycles after request.
- amt 0 -> done 2 cycles after request, short=0, coin_valid never asserted.
- HOPPER_DEPTH=1, amt 9 -> coins 11, 10, 01 acked; done, short=1, owed=3.
- amt 5, never ack, ACK_TIMEOUT=8 -> coin_valid held 8 cycles then jam=1, owed=5, no done. Refill -> IDLE, jam=0, inventories=HOPPER_DEPTH. Also: ack on 8th cycle -> no jam, inv3 decremented.
- change_valid pulsed while busy -> ignored; amt 6 with reset_n low mid-ISSUE -> coin_valid, busy, done drop asynchronously, inventories reload.
- LOW_STOCK_EN, HOPPER_DEPTH=4, LOW_MARK=2: two amt-3 payouts -> low_stock rises the cycle after inv3 becomes 2. Refill -> low_stock=0.

Source files
------------

// File: rtl/change_payout.sv
// rtl/change_payout.sv - coin hopper payout controller with greedy selection and jam detection
// Optional: define LOW_STOCK_EN to enable the registered low_stock flag.
module change_payout #(
  parameter int HOPPER_DEPTH = 15,
  parameter int ACK_TIMEOUT  = 8,
  parameter int LOW_MARK     = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_change_valid,
  input  logic [3:0] i_change_amt,
  output logic       o_busy,
  output logic [1:0] o_coin_out,
  output logic       o_coin_valid,
  input  logic       i_coin_ack,
  input  logic       i_refill,
  output logic       o_done,
  output logic       o_short,
  output logic [3:0] o_owed,
  output logic       o_jam,
  output logic       o_low_stock
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_DONE, S_JAM} state_t;

  localparam logic [3:0] LP_DEPTH    = 4'(HOPPER_DEPTH);
  localparam logic [3:0] LP_TMO_LAST = 4'(ACK_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_remaining;
  logic [3:0] r_owed;
  logic [3:0] r_tmo;
  logic [3:0] r_inv1;
  logic [3:0] r_inv2;
  logic [3:0] r_inv3;
  logic [1:0] r_coin;
  logic [1:0] w_sel;
  logic       w_refill_ok;

  // Refill only reloads the hopper while nothing is being paid out
  assign w_refill_ok = i_refill && ((r_state == S_IDLE) || (r_state == S_JAM));

  // Greedy pick: largest coin that fits the remainder and is still in stock
  always_comb begin
    w_sel = 2'd0;
    if ((r_remaining >= 4'd3) && (r_inv3 != 4'd0)) begin
      w_sel = 2'd3;
    end else if ((r_remaining >= 4'd2) && (r_inv2 != 4'd0)) begin
      w_sel = 2'd2;
    end else if ((r_remaining >= 4'd1) && (r_inv1 != 4'd0)) begin
      w_sel = 2'd1;
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a late ack on the final timeout cycle still counts
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_change_valid) w_next = S_SELECT;
      S_SELECT: w_next = (w_sel == 2'd0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (i_coin_ack) begin
          w_next = S_SELECT;
        end else if (r_tmo == LP_TMO_LAST) begin
          w_next = S_JAM;
        end
      end
      S_DONE:   w_next = S_IDLE;
      S_JAM:    if (i_refill) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Payout bookkeeping: remainder, latched coin, ack timer and owed report
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_remaining <= 4'd0;
      r_owed      <= 4'd0;
      r_tmo       <= 4'd0;
      r_coin      <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_change_valid) begin
            r_remaining <= i_change_amt;
            r_owed      <= 4'd0;
          end
        end
        S_SELECT: begin
          r_coin <= w_sel;
          r_tmo  <= 4'd0;
          if (w_sel == 2'd0) r_owed <= r_remaining;
        end
        S_ISSUE: begin
          if (i_coin_ack) begin
            r_remaining <= r_remaining - {2'b00, r_coin};
          end else if (r_tmo == LP_TMO_LAST) begin
            r_owed <= r_remaining;
          end else begin
            r_tmo <= r_tmo + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-denomination inventory: decrement on ack, reload on refill
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_inv1 <= LP_DEPTH;
      r_inv2 <= LP_DEPTH;
      r_inv3 <= LP_DEPTH;
    end else if (w_refill_ok) begin
      r_inv1 <= LP_DEPTH;
      r_inv2 <= LP_DEPTH;
      r_inv3 <= LP_DEPTH;
    end else if ((r_state == S_ISSUE) && i_coin_ack) begin
      case (r_coin)
        2'd1:    r_inv1 <= r_inv1 - 4'd1;
        2'd2:    r_inv2 <= r_inv2 - 4'd1;
        2'd3:    r_inv3 <= r_inv3 - 4'd1;
        default: ;
      endcase
    end
  end

  // Outputs decoded purely from registered state
  always_comb begin
    o_busy       = (r_state != S_IDLE);
    o_coin_valid = (r_state == S_ISSUE);
    o_coin_out   = (r_state == S_ISSUE) ? r_coin : 2'b00;
    o_done       = (r_state == S_DONE);
    o_short      = (r_state == S_DONE) && (r_remaining != 4'd0);
    o_jam        = (r_state == S_JAM);
    o_owed       = r_owed;
  end

`ifdef LOW_STOCK_EN
  localparam logic [3:0] LP_LOW_MARK = 4'(LOW_MARK);
  logic r_low_stock;

  // Low-stock flag follows inventory one cycle later
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_low_stock <= 1'b0;
    end else begin
      r_low_stock <= (r_inv1 <= LP_LOW_MARK) || (r_inv2 <= LP_LOW_MARK) ||
                     (r_inv3 <= LP_LOW_MARK);
    end
  end

  assign o_low_stock = r_low_stock;
`else
  assign o_low_stock = 1'b0 & (LOW_MARK != 0);
`endif

endmodule
